// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Program-counter and fetch-register stage in front of the instruction memory.
// The PC drives the memory byte address directly. The memory returns its word
// combinationally, and this stage registers that word together with its PC.
// The stage handles sequential advance, redirect with wrong-path flush, and
// stall. A misaligned or out-of-range next PC halts the unit with a trap.
//
// Optional feature: define FETCH_PERF_EN to add the saturating performance
// counters fetch_count and flush_count.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   stall            hold PC and fetch register
//   redirect         branch/jump taken; load redirect_target into the PC
//   redirect_target  new PC for a redirect
//   trap_clear       leave HALT and restart from RESET_VECTOR
//   address_out      current PC, instruction memory byte address
//   inst_in          memory word at address_out (combinational)
//   inst_out         registered instruction
//   inst_pc          PC of inst_out
//   inst_valid       inst_out holds a valid, non-flushed instruction
//   trap             fetch fault, unit halted
//   trap_cause       2'b01 misaligned, 2'b10 out of range
//   trap_addr        faulting address
//   fetch_count      (FETCH_PERF_EN) cycles in which inst_valid loads 1
//   flush_count      (FETCH_PERF_EN) accepted redirects
//
// State table:
//   BOOT | one-cycle hold after reset or trap_clear; no fetch
//   RUN  | normal fetch, redirect and stall
//   HALT | fault held until trap_clear

module pc_fetch_unit #(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int unsigned MEM_BYTES    = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  input  logic        trap_clear,
  output logic [63:0] address_out,
  input  logic [31:0] inst_in,
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc,
  output logic        inst_valid,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [63:0] trap_addr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES) - 64'd4;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;
  logic [63:0] taddr_q, taddr_d;

  logic [63:0] cand;
  logic [1:0]  cand_fault;
  logic        advance;

  // The next-PC candidate is either the redirect target or PC+4. Misalignment
  // is checked first, so it wins when both faults apply.
  always_comb begin
    cand = redirect ? redirect_target : (pc_q + 64'd4);
    if (cand[1:0] != 2'b00) begin
      cand_fault = 2'b01;
    end else if (cand > LAST_ADDR) begin
      cand_fault = 2'b10;
    end else begin
      cand_fault = 2'b00;
    end
    advance = redirect | ~stall;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_out_d = inst_out_q;
    inst_pc_d  = inst_pc_q;
    valid_d    = valid_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    taddr_d    = taddr_q;

    unique case (state_q)
      BOOT: begin
        valid_d = 1'b0;
        state_d = RUN;
      end

      RUN: begin
        if (advance) begin
          if (redirect) begin
            // Flush the wrong-path word but keep its payload.
            valid_d = 1'b0;
          end else begin
            // Commit the current word even when PC+4 is about to fault.
            inst_out_d = inst_in;
            inst_pc_d  = pc_q;
            valid_d    = 1'b1;
          end

          if (cand_fault != 2'b00) begin
            state_d = HALT;
            trap_d  = 1'b1;
            cause_d = cand_fault;
            taddr_d = cand;
          end else begin
            pc_d = cand;
          end
        end
      end

      HALT: begin
        valid_d = 1'b0;
        if (trap_clear) begin
          pc_d    = RESET_VECTOR;
          trap_d  = 1'b0;
          cause_d = 2'b00;
          state_d = BOOT;
        end
      end

      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      inst_out_q <= 32'd0;
      inst_pc_q  <= 64'd0;
      valid_q    <= 1'b0;
      trap_q     <= 1'b0;
      cause_q    <= 2'b00;
      taddr_q    <= 64'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_out_q <= inst_out_d;
      inst_pc_q  <= inst_pc_d;
      valid_q    <= valid_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
      taddr_q    <= taddr_d;
    end
  end

  assign address_out = pc_q;
  assign inst_out    = inst_out_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = valid_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign trap_addr   = taddr_q;

`ifdef FETCH_PERF_EN
  logic        fetch_inc;
  logic        flush_inc;
  logic [31:0] fetch_cnt_q;
  logic [15:0] flush_cnt_q;

  // A sequential fetch loads inst_valid=1 even on a PC+4 fault cycle.
  // A redirect counts only when it is accepted, not when it traps.
  assign fetch_inc = (state_q == RUN) && !redirect && !stall;
  assign flush_inc = (state_q == RUN) && redirect && (cand_fault == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (fetch_inc && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (flush_inc && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_target;
  logic        trap_clear;
  logic [63:0] address_out;
  logic [31:0] inst_in;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [63:0] trap_addr;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  int vectors;
  int miscompares;

  logic [31:0] mem [0:127];

  pc_fetch_unit #(
    .RESET_VECTOR(64'h0),
    .MEM_BYTES(512)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .trap_clear(trap_clear),
    .address_out(address_out),
    .inst_in(inst_in),
    .inst_out(inst_out),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .trap(trap),
    .trap_cause(trap_cause),
    .trap_addr(trap_addr)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: mem[i] = {16'hC0DE, byte address}.
  assign inst_in = (address_out < 64'd512) ? mem[address_out[8:2]] : 32'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++;
    if ({address_out, inst_out, inst_pc, inst_valid, trap, trap_cause, trap_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got addr=%h inst=%h pc=%h v=%b trap=%b cause=%b taddr=%h, expected all zero",
               address_out, inst_out, inst_pc, inst_valid, trap, trap_cause, trap_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (address_out !== 64'd0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_state: got addr=%h v=%b, expected addr=0 v=0", address_out, inst_valid);
    end
  endtask

  task automatic test_boot_seq();
    step();  // BOOT -> RUN
    vectors++;
    if (address_out !== 64'd0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_hold: got addr=%h v=%b, expected addr=0 v=0", address_out, inst_valid);
    end
    step();
    vectors++;
    if (inst_pc !== 64'd0 || inst_valid !== 1'b1 || inst_out !== 32'hC0DE_0000 || address_out !== 64'd4) begin
      miscompares++;
      $display("FAIL seq_word0: got pc=%h v=%b inst=%h addr=%h, expected pc=0 v=1 inst=c0de0000 addr=4",
               inst_pc, inst_valid, inst_out, address_out);
    end
    step();
    vectors++;
    if (inst_pc !== 64'd4 || inst_valid !== 1'b1 || inst_out !== 32'hC0DE_0004 || address_out !== 64'd8) begin
      miscompares++;
      $display("FAIL seq_word4: got pc=%h v=%b inst=%h addr=%h, expected pc=4 v=1 inst=c0de0004 addr=8",
               inst_pc, inst_valid, inst_out, address_out);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (address_out !== 64'd8 || inst_pc !== 64'd4 || inst_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got addr=%h pc=%h v=%b, expected addr=8 pc=4 v=1",
                 i, address_out, inst_pc, inst_valid);
      end
    end
    stall = 1'b0;
    step();
    vectors++;
    if (inst_pc !== 64'd8 || inst_out !== 32'hC0DE_0008 || inst_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release8: got pc=%h inst=%h v=%b, expected pc=8 inst=c0de0008 v=1",
               inst_pc, inst_out, inst_valid);
    end
    step();
    vectors++;
    if (inst_pc !== 64'd12 || address_out !== 64'd16) begin
      miscompares++;
      $display("FAIL stall_release12: got pc=%h addr=%h, expected pc=c addr=10", inst_pc, address_out);
    end
  endtask

  task automatic test_redirect();
    step();  // captures 16, PC=20
    redirect = 1'b1;
    redirect_target = 64'd40;
    step();
    vectors++;
    if (address_out !== 64'd40 || inst_valid !== 1'b0 || inst_pc !== 64'd16) begin
      miscompares++;
      $display("FAIL redirect_flush: got addr=%h v=%b pc=%h, expected addr=28 v=0 pc=10",
               address_out, inst_valid, inst_pc);
    end
    redirect = 1'b0;
    step();
    vectors++;
    if (inst_pc !== 64'd40 || inst_out !== 32'hC0DE_0028 || inst_valid !== 1'b1 || address_out !== 64'd44) begin
      miscompares++;
      $display("FAIL redirect_target_word: got pc=%h inst=%h v=%b addr=%h, expected pc=28 inst=c0de0028 v=1 addr=2c",
               inst_pc, inst_out, inst_valid, address_out);
    end
  endtask

  task automatic test_back_to_back();
    // Redirect and stall together: the redirect wins.
    stall = 1'b1;
    redirect = 1'b1;
    redirect_target = 64'd100;
    step();
    vectors++;
    if (address_out !== 64'd100 || inst_valid !== 1'b0 || inst_pc !== 64'd40) begin
      miscompares++;
      $display("FAIL redirect_over_stall: got addr=%h v=%b pc=%h, expected addr=64 v=0 pc=28",
               address_out, inst_valid, inst_pc);
    end
    redirect = 1'b0;
    step();
    vectors++;
    if (address_out !== 64'd100 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_after_redirect: got addr=%h v=%b, expected addr=64 v=0", address_out, inst_valid);
    end
    stall = 1'b0;
    step();
    vectors++;
    if (inst_pc !== 64'd100 || inst_out !== 32'hC0DE_0064 || inst_valid !== 1'b1 || address_out !== 64'd104) begin
      miscompares++;
      $display("FAIL resume_after_redirect: got pc=%h inst=%h v=%b addr=%h, expected pc=64 inst=c0de0064 v=1 addr=68",
               inst_pc, inst_out, inst_valid, address_out);
    end
  endtask

  task automatic test_misaligned();
    redirect = 1'b1;
    redirect_target = 64'd42;
    step();
    vectors++;
    if (trap !== 1'b1 || trap_cause !== 2'b01 || trap_addr !== 64'd42 || address_out !== 64'd104 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL misaligned_trap: got trap=%b cause=%b taddr=%h addr=%h v=%b, expected 1 01 2a 68 0",
               trap, trap_cause, trap_addr, address_out, inst_valid);
    end
    // In HALT, redirect and stall are ignored.
    redirect_target = 64'd200;
    stall = 1'b1;
    step();
    vectors++;
    if (address_out !== 64'd104 || trap_addr !== 64'd42 || trap !== 1'b1 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_hold: got addr=%h taddr=%h trap=%b v=%b, expected addr=68 taddr=2a trap=1 v=0",
               address_out, trap_addr, trap, inst_valid);
    end
    redirect = 1'b0;
    stall = 1'b0;
    trap_clear = 1'b1;
    step();
    trap_clear = 1'b0;
    vectors++;
    if (trap !== 1'b0 || trap_cause !== 2'b00 || address_out !== 64'd0 || trap_addr !== 64'd42 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL trap_clear: got trap=%b cause=%b addr=%h taddr=%h v=%b, expected 0 00 0 2a 0",
               trap, trap_cause, address_out, trap_addr, inst_valid);
    end
    step();  // BOOT -> RUN
    vectors++;
    if (address_out !== 64'd0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_boot: got addr=%h v=%b, expected addr=0 v=0", address_out, inst_valid);
    end
    step();
    vectors++;
    if (inst_pc !== 64'd0 || inst_valid !== 1'b1 || address_out !== 64'd4) begin
      miscompares++;
      $display("FAIL clear_restart: got pc=%h v=%b addr=%h, expected pc=0 v=1 addr=4", inst_pc, inst_valid, address_out);
    end
  endtask

  task automatic test_range_redirect();
    // Misaligned and out of range at once: the cause is misaligned.
    redirect = 1'b1;
    redirect_target = 64'h203;
    step();
    redirect = 1'b0;
    vectors++;
    if (trap !== 1'b1 || trap_cause !== 2'b01 || trap_addr !== 64'h203 || address_out !== 64'd4) begin
      miscompares++;
      $display("FAIL both_fault_cause: got trap=%b cause=%b taddr=%h addr=%h, expected 1 01 203 4",
               trap, trap_cause, trap_addr, address_out);
    end
    trap_clear = 1'b1;
    step();
    trap_clear = 1'b0;
    step();  // BOOT -> RUN
    redirect = 1'b1;
    redirect_target = 64'd512;
    step();
    redirect = 1'b0;
    vectors++;
    if (trap !== 1'b1 || trap_cause !== 2'b10 || trap_addr !== 64'd512 || address_out !== 64'd0) begin
      miscompares++;
      $display("FAIL range_redirect: got trap=%b cause=%b taddr=%h addr=%h, expected 1 10 200 0",
               trap, trap_cause, trap_addr, address_out);
    end
    trap_clear = 1'b1;
    step();
    trap_clear = 1'b0;
    step();  // BOOT -> RUN
  endtask

  task automatic test_end_of_memory();
    redirect = 1'b1;
    redirect_target = 64'd504;
    step();
    redirect = 1'b0;
    vectors++;
    if (address_out !== 64'd504 || trap !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_504: got addr=%h trap=%b, expected addr=1f8 trap=0", address_out, trap);
    end
    step();
    vectors++;
    if (inst_pc !== 64'd504 || inst_valid !== 1'b1 || address_out !== 64'd508 || trap !== 1'b0) begin
      miscompares++;
      $display("FAIL word_504: got pc=%h v=%b addr=%h trap=%b, expected pc=1f8 v=1 addr=1fc trap=0",
               inst_pc, inst_valid, address_out, trap);
    end
    step();
    vectors++;
    if (inst_pc !== 64'd508 || inst_out !== 32'hC0DE_01FC || inst_valid !== 1'b1 ||
        trap !== 1'b1 || trap_cause !== 2'b10 || trap_addr !== 64'd512 || address_out !== 64'd508) begin
      miscompares++;
      $display("FAIL last_word_trap: got pc=%h inst=%h v=%b trap=%b cause=%b taddr=%h addr=%h, expected 1fc c0de01fc 1 1 10 200 1fc",
               inst_pc, inst_out, inst_valid, trap, trap_cause, trap_addr, address_out);
    end
    step();
    vectors++;
    if (inst_valid !== 1'b0 || trap !== 1'b1 || address_out !== 64'd508 || inst_pc !== 64'd508) begin
      miscompares++;
      $display("FAIL halt_after_last: got v=%b trap=%b addr=%h pc=%h, expected 0 1 1fc 1fc",
               inst_valid, trap, address_out, inst_pc);
    end
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({address_out, inst_out, inst_pc, inst_valid, trap, trap_cause, trap_addr} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got addr=%h inst=%h pc=%h v=%b trap=%b cause=%b taddr=%h, expected all zero",
               address_out, inst_out, inst_pc, inst_valid, trap, trap_cause, trap_addr);
    end
`ifdef FETCH_PERF_EN
    vectors++;
    if (fetch_count !== 32'd0 || flush_count !== 16'd0) begin
      miscompares++;
      $display("FAIL perf_reset: got fetch=%0d flush=%0d, expected 0 0", fetch_count, flush_count);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    step();  // BOOT -> RUN
    vectors++;
    if (inst_valid !== 1'b0 || address_out !== 64'd0) begin
      miscompares++;
      $display("FAIL post_reset_boot: got v=%b addr=%h, expected v=0 addr=0", inst_valid, address_out);
    end
    step();
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'd0 || inst_out !== 32'hC0DE_0000) begin
      miscompares++;
      $display("FAIL post_reset_fetch: got v=%b pc=%h inst=%h, expected 1 0 c0de0000", inst_valid, inst_pc, inst_out);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 128; i++) mem[i] = {16'hC0DE, 16'(i * 4)};
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 64'd0;
    trap_clear = 1'b0;

    test_reset();
    test_boot_seq();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_misaligned();
    test_range_redirect();
    test_end_of_memory();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-register stage directly upstream of the instruction memory.
- Drives the byte address into the instruction memory and registers the returned 32-bit word together with its PC for the decode/execute logic.
- Handles sequential advance, branch/jump redirect with wrong-path flush, stall, and a halt-on-fault trap for misaligned or out-of-range fetch addresses.

Parameters:
- RESET_VECTOR, 64'h0, PC value loaded on reset and on trap_clear.
- MEM_BYTES, 512, instruction memory size in bytes; a fetch address above MEM_BYTES-4 is out of range.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold PC and fetch register
- redirect  input  1  branch taken or jump, resolved by the instruction currently in the fetch register
- redirect_target  input  64  new PC, used when redirect=1
- trap_clear  input  1  leave HALT, restart from RESET_VECTOR
- address_out  output  64  current PC, connected to the instruction memory byte address
- inst_in  input  32  instruction word returned by the instruction memory for address_out (combinational)
- inst_out  output  32  registered instruction
- inst_pc  output  64  PC of inst_out
- inst_valid  output  1  inst_out is a valid, non-flushed instruction
- trap  output  1  fetch fault; unit is halted
- trap_cause  output  2  2'b01 misaligned target, 2'b10 out of range
- trap_addr  output  64  faulting address

Behaviour:
- Reset (async, rst=1): state=BOOT, PC=RESET_VECTOR, inst_out=0, inst_pc=0, inst_valid=0, trap=0, trap_cause=0, trap_addr=0.
- address_out always equals PC; memory read is combinational, so the fetch register captures inst_in in the same cycle.
- States:
  - BOOT: lasts exactly one cycle after reset deasserts. PC is held and inst_valid stays 0. Then go to RUN.
  - RUN: normal fetch.
  - HALT: fault held.
- RUN priority per cycle, highest first:
  - 1. Fault check on the next-PC candidate.
  - 2. Redirect.
  - 3. Stall.
  - 4. Sequential advance.
- Sequential (no redirect, no stall):
  - Fetch register <= {inst_in, PC}, inst_valid <= 1.
  - PC <= PC+4, modulo 2^64.
- Stall=1 (no redirect): PC, inst_out, inst_pc and inst_valid all hold.
- Redirect=1:
  - PC <= redirect_target.
  - inst_valid <= 0 (flush of the wrong-path word at the old PC). inst_out and inst_pc hold their previous values.
  - Redirect wins over a simultaneous stall; the redirect is never lost.
- Fault on candidate next PC:
  - Misaligned: redirect_target[1:0] != 0 → cause 01.
  - Out of range: candidate > MEM_BYTES-4 → cause 10. Applies to redirect targets and to the PC+4 result.
  - Misaligned takes precedence if both apply.
  - On fault: state <= HALT, trap <= 1, trap_cause and trap_addr <= candidate, PC unchanged, inst_valid <= 0.
  - A sequential-advance fault still commits the current word: the fetch register loads {inst_in, PC} and inst_valid pulses for that cycle. inst_valid drops to 0 in HALT on the following cycle.
- HALT:
  - All registers hold and inst_valid=0.
  - stall and redirect are ignored.
  - trap_clear=1 → PC <= RESET_VECTOR, trap <= 0, trap_cause <= 0, state <= BOOT. trap_addr holds.
- trap_clear outside HALT is ignored.
- rst asserted in any state, mid-stall or mid-trap, immediately returns to the reset values.
- PC wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0: arithmetic wraps, but with MEM_BYTES < 2^64 the out-of-range fault fires first.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output fetch_count[31:0], counting cycles in which inst_valid is loaded with 1.
  - Adds output flush_count[15:0], counting accepted redirects.
  - Both counters reset to 0 on rst and saturate at all-ones. They do not clear on trap_clear.
- Not defined: both ports and counters are absent; remaining behaviour is identical.

Test Plan:
- Reset release, RESET_VECTOR=0, memory holds words at 0, 4, 8:
  - BOOT cycle: address_out=0, inst_valid=0.
  - Then inst_pc=0, 4, 8 on consecutive cycles, inst_valid=1, inst_out matches the memory words.
- Sequential run, PC=8, stall=1 for 3 cycles then 0:
  - address_out stays 8; inst_pc stays at the last captured value (4); inst_valid stays 1.
  - On release: inst_pc=8, then 12.
- Sequential run, PC=20, redirect=1, target=40:
  - Next cycle: address_out=40, inst_valid=0.
  - Following cycle: inst_pc=40, inst_out=mem[40..43].
- Redirect=1 with target=42 (misaligned):
  - trap=1, trap_cause=01, trap_addr=42, address_out unchanged.
  - trap_clear=1 → BOOT, address_out=0.
- MEM_BYTES=512, PC reaches 508:
  - Word at 508 captured with inst_valid=1.
  - Same edge: trap=1, trap_cause=10, trap_addr=512.
  - Next cycle: inst_valid=0.
- rst pulsed asynchronously mid-cycle while halted with stall=1:
  - Outputs go immediately to reset values.
  - With FETCH_PERF_EN defined: fetch_count=0 and flush_count=0.
